// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-and-add signed multiplier.
// The FSM state encoding and the index of the final (subtracting) iteration live here.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'd7;

endpackage

// File: rtl/shift_add_mult_addsub9.sv
// 9-bit adder/subtractor shared by every iteration of the multiplier.
// When fn=1 the operand B is inverted and a carry-in of 1 is added, giving A-B.
module addsub9 (
    input  logic [8:0] A,
    input  logic [8:0] B,
    input  logic       fn,
    output logic [8:0] S
);

    assign S = A + (B ^ {9{fn}}) + {8'd0, fn};

endmodule

// File: rtl/shift_add_mult.sv
// Sequential signed multiplier: 8 add-then-arithmetic-shift iterations over {X,A,B}.
// Last iteration subtracts, since the multiplier's MSB carries negative weight.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 x
);

    state_t           state, state_next;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             x_q;
    logic [2:0]       cnt_q;
    logic             done_q;
    logic [WIDTH:0]   sum;
    logic             last_iter;

    assign last_iter = (cnt_q == LAST_ITER);

    // A[7] always equals X whenever ADD runs, so {A[7],A} is the exact 9-bit partial sum.
    addsub9 u_addsub9 (
        .A  ({a_q[WIDTH-1], a_q}),
        .B  ({s_q[WIDTH-1], s_q}),
        .fn (last_iter),
        .S  (sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults come first so no path through the case leaves an output
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = ADD;
            end
            ADD:   state_next = SHIFT;
            SHIFT: state_next = last_iter ? DONE : ADD;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // Registered pulse: high for the single cycle after DONE, while the product is stable.
            done_q <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        s_q   <= a_in;
                        b_q   <= b_in;
                        a_q   <= '0;
                        x_q   <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ADD: begin
                    if (b_q[0]) begin
                        {x_q, a_q} <= sum;
                    end
                end
                SHIFT: begin
                    {x_q, a_q, b_q} <= {x_q, x_q, a_q, b_q[WIDTH-1:1]};
                    if (!last_iter) cnt_q <= cnt_q + 3'd1;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign done    = done_q;
    assign product = {a_q, b_q};
    assign x       = x_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult with hand-computed products.
// Covers latency, sign handling, ignored/held start, and mid-operation reset.
module tb_shift_add_mult;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        x;

    int checks   = 0;
    int failures = 0;

    shift_add_mult #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product),
        .x       (x)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete multiply: accept, measure edges to done, check result and pulse width.
    task automatic do_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_p, input logic exp_x);
        int n;
        bit seen;
        @(negedge Clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        check({tag, "_lat"}, n, 17);
        check({tag, "_prod"}, product, exp_p);
        check({tag, "_x"}, x, exp_x);
        check({tag, "_idle"}, busy, 0);
        @(posedge Clk);
        #1;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_hold"}, product, exp_p);
    endtask

    initial begin
        int n;
        int ndone;
        int d1;
        int d2;
        logic [15:0] p1;
        logic [15:0] p2;

        Reset_n = 1'b0;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_prod", product, 0);
        check("rst_x", x, 0);
        #21;
        Reset_n = 1'b1;

        do_mult("m7x3", 8'h07, 8'h03, 16'h0015, 1'b0);
        do_mult("mn3x7", 8'hFD, 8'h07, 16'hFFEB, 1'b1);
        do_mult("m7xn3", 8'h07, 8'hFD, 16'hFFEB, 1'b1);
        do_mult("mmin", 8'h80, 8'h80, 16'h4000, 1'b0);
        do_mult("m0xff", 8'h00, 8'hFF, 16'h0000, 1'b0);

        // start re-pulsed mid-operation with new operands must be ignored
        @(negedge Clk);
        a_in  = 8'hFD;
        b_in  = 8'h07;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        ndone = 0;
        p1    = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk);
            #1;
            if (i == 5) begin
                a_in  = 8'h11;
                b_in  = 8'h22;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                p1 = product;
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_prod", p1, 16'hFFEB);

        // reset between edges while in SHIFT aborts the operation at once
        @(negedge Clk);
        a_in  = 8'h07;
        b_in  = 8'h03;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_prod", product, 0);
        check("abort_done", done, 0);
        #10;
        Reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk);
            #1;
            if (done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        do_mult("post_rst", 8'h07, 8'h03, 16'h0015, 1'b0);

        // start held high: back-to-back operations, second reloads new operands
        @(negedge Clk);
        a_in  = 8'h05;
        b_in  = 8'h06;
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        p1 = '0;
        p2 = '0;
        n  = 0;
        while (d2 < 0 && n < 80) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 1) begin
                a_in = 8'hF0;
                b_in = 8'h0A;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    p1 = product;
                end else begin
                    d2 = n;
                    p2 = product;
                end
            end
        end
        start = 1'b0;
        check("held_first_lat", d1, 18);
        check("held_gap", d2 - d1, 18);
        check("held_prod1", p1, 16'h001E);
        check("held_prod2", p2, 16'hFF60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; only 8 is supported.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level request to begin a multiply; sampled only in IDLE.
REQ-005 a_in  input  8  multiplicand S, two's complement; captured on accepted start.
REQ-006 b_in  input  8  multiplier B, two's complement; captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse marking product valid.
REQ-009 product  output  16  {A,B} register pair; signed a_in*b_in once done pulses.
REQ-010 x  output  1  sign-extension bit X.

Function
REQ-011 The block SHALL compute the signed 16-bit product by 8 iterations of add-then-arithmetic-shift-right over {X,A,B}, using one shared add/sub datapath.
REQ-012 States SHALL be IDLE, ADD, SHIFT, DONE, with a 3-bit iteration counter cnt.
REQ-013 IDLE with start=1 SHALL load S<=a_in, B<=b_in, A<=0, X<=0, cnt<=0 and go to ADD; IDLE with start=0 SHALL hold all registers.
REQ-014 ADD with B[0]=1 SHALL set A<=low 8 bits and X<=bit 8 of the 9-bit sign-extended result A+S for cnt<7, or A-S for cnt==7.
REQ-015 ADD with B[0]=0 SHALL leave A and X unchanged; ADD SHALL always go to SHIFT.
REQ-016 SHIFT SHALL set {X,A,B} <= {X,X,A,B[7:1]} (arithmetic right shift, X retained).
REQ-017 SHIFT SHALL then go to DONE if cnt==7; otherwise it SHALL increment cnt and go to ADD.
REQ-018 DONE SHALL assert done for exactly one cycle, hold A/B/X, and go to IDLE.
REQ-019 Latency: done SHALL be high in the cycle starting 17 edges after the edge that accepted start. The operation SHALL take exactly 16 ADD/SHIFT cycles regardless of operand values.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high through DONE SHALL begin a new operation on the first IDLE edge, reloading all operands.
REQ-022 product SHALL keep the last result in IDLE until the next accepted start.
REQ-023 Overflow cannot occur: the 9-bit add/sub result and the 16-bit product SHALL be exact for all operands, including -128 * -128.

Reset
REQ-024 Reset_n low SHALL immediately force state=IDLE, A=B=S=0, X=0, cnt=0, busy=0, done=0, product=0, independent of Clk.
REQ-025 Reset during any state SHALL abort the operation; no done pulse SHALL follow.
REQ-026 After Reset_n rises, the first start SHALL be accepted on the first rising edge at which start=1.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, ADD, SHIFT, DONE) and the constant LAST_ITER=7.
REQ-028 The add/sub datapath SHALL be one sub-module, addsub9: ports A[8:0], B[8:0], fn, S[8:0]; B is XORed with fn and fn is the carry-in.
REQ-029 The controller SHALL feed addsub9 with sign-extended A and S, and fn=(cnt==LAST_ITER).

Verification
REQ-030 a_in=0x07, b_in=0x03, start -> done 17 cycles later, product=0x0015, x=0.
REQ-031 a_in=0xFD (-3), b_in=0x07 -> product=0xFFEB (-21); a_in=0x07, b_in=0xFD -> product=0xFFEB, exercising the final subtract.
REQ-032 a_in=0x80, b_in=0x80 -> product=0x4000; a_in=0x00, b_in=0xFF -> product=0x0000.
REQ-033 Pulse start again at cycle 5 of an operation with different operands -> first result unaffected; no second done.
REQ-034 Drop Reset_n low mid-SHIFT, between clock edges -> busy=0 and product=0 immediately; no done. A new start after release -> correct product.
REQ-035 Hold start high continuously for two operations -> done pulses 18 cycles apart; both products correct.
